// File: rtl/rv_wb_timer.sv
// rv_wb_timer -- Wishbone machine timer for the RV SoC.
//
// A 64-bit mtime counter advanced by a programmable prescaler, plus NUM_CMP
// independent 64-bit compare channels. Each channel raises a level interrupt
// (mtime >= cmp_k) gated by its IEN bit; irq_timer is the OR of the gated
// channels. All outputs are registered.
//
// Register map (byte offsets, wb_adr[1:0] ignored):
//   0x00 MTIME_LO  rw      0x04 MTIME_HI  rw
//   0x08 CTRL      rw      bit0 EN, bits [8+PRESCALE_W-1:8] PRESC
//   0x0C STATUS    ro      bit k = raw match of channel k
//   0x10 IEN       rw      bits [NUM_CMP-1:0]
//   0x20+8k CMPk_LO, 0x24+8k CMPk_HI  rw, k < NUM_CMP
//   Anything else reads 0, ignores writes, and is still acknowledged.
//
// Parameters:
//   NUM_CMP     number of compare channels, 1..4
//   PRESCALE_W  width of the PRESC field, 1..24
//
// Ports:
//   wb_clk, wb_rst_n             clock, asynchronous active-low reset
//   wb_adr, wb_dat_w, wb_sel     byte address, write data, byte enables
//   wb_we, wb_cyc, wb_stb        Wishbone control
//   wb_dat_r, wb_ack             read data (0 unless acking), single-cycle ack
//   irq_cmp, irq_timer           per-channel and combined timer interrupts
//
// Build option:
//   TIMER_SHADOW_EN  when defined, a read of MTIME_LO latches mtime[63:32]
//                    into a shadow that MTIME_HI reads return, giving a
//                    tear-free LO-then-HI read. Otherwise MTIME_HI is live.

module rv_wb_timer #(
    parameter int NUM_CMP    = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic               wb_clk,
    input  logic               wb_rst_n,
    input  logic [5:0]         wb_adr,
    input  logic [31:0]        wb_dat_w,
    input  logic [3:0]         wb_sel,
    input  logic               wb_we,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    output logic [31:0]        wb_dat_r,
    output logic               wb_ack,
    output logic [NUM_CMP-1:0] irq_cmp,
    output logic               irq_timer
);

    // Byte-enable merge of a 32-bit register with bus write data.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]           mtime_r;
    logic [63:0]           mtime_nxt_s;
    logic [PRESCALE_W-1:0] pcnt_r;
    logic [PRESCALE_W-1:0] pcnt_nxt_s;
    logic                  en_r;
    logic [PRESCALE_W-1:0] presc_r;
    logic [NUM_CMP-1:0]    ien_r;
    logic [63:0]           cmp_r [NUM_CMP];
    logic                  ack_r;
    logic [31:0]           dat_r_r;
    logic [NUM_CMP-1:0]    irq_cmp_r;
    logic                  irq_timer_r;

    logic                  req_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [3:0]            adr_word_s;
    logic                  wr_mtime_lo_s;
    logic                  wr_mtime_hi_s;
    logic                  wr_ctrl_s;
    logic                  wr_ien_s;
    logic [NUM_CMP-1:0]    cmp_hit_s;
    logic [NUM_CMP-1:0]    match_s;
    logic                  tick_s;
    logic [31:0]           wmask_s;
    logic [31:0]           ctrl_rd_s;
    logic [31:0]           cmp_rd_s;
    logic [31:0]           mtime_hi_rd_s;
    logic [31:0]           rdata_s;
    logic                  unused_adr_s;

    // A new request is only taken while no ack is outstanding, which
    // enforces the ack-high / ack-low two-cycle rhythm.
    assign req_s         = wb_cyc & wb_stb & ~ack_r;
    assign wr_s          = req_s & wb_we;
    assign rd_s          = req_s & ~wb_we;
    assign adr_word_s    = wb_adr[5:2];
    assign wr_mtime_lo_s = wr_s & (adr_word_s == 4'h0);
    assign wr_mtime_hi_s = wr_s & (adr_word_s == 4'h1);
    assign wr_ctrl_s     = wr_s & (adr_word_s == 4'h2);
    assign wr_ien_s      = wr_s & (adr_word_s == 4'h4);
    assign tick_s        = en_r & (pcnt_r == presc_r);
    assign wmask_s       = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    assign unused_adr_s  = ^wb_adr[1:0];

    assign wb_ack    = ack_r;
    assign wb_dat_r  = dat_r_r;
    assign irq_cmp   = irq_cmp_r;
    assign irq_timer = irq_timer_r;

    // Channel address decode and unsigned compare against mtime.
    always_comb begin
        cmp_hit_s = '0;
        match_s   = '0;
        for (int k = 0; k < NUM_CMP; k++) begin
            cmp_hit_s[k] = wb_adr[5] & (wb_adr[4:3] == 2'(k));
            match_s[k]   = (mtime_r >= cmp_r[k]);
        end
    end

    // Prescaler and mtime next state; a bus write to either mtime half
    // overrides (and so drops) a coincident tick.
    always_comb begin
        pcnt_nxt_s  = pcnt_r;
        mtime_nxt_s = mtime_r;
        if (wr_ctrl_s) begin
            pcnt_nxt_s = '0;
        end else if (tick_s) begin
            pcnt_nxt_s = '0;
        end else if (en_r) begin
            pcnt_nxt_s = pcnt_r + PRESCALE_W'(1);
        end else begin
            pcnt_nxt_s = pcnt_r;
        end
        if (wr_mtime_lo_s) begin
            mtime_nxt_s = {mtime_r[63:32], byte_merge(mtime_r[31:0], wb_dat_w, wb_sel)};
        end else if (wr_mtime_hi_s) begin
            mtime_nxt_s = {byte_merge(mtime_r[63:32], wb_dat_w, wb_sel), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

`ifdef TIMER_SHADOW_EN
    logic [31:0] shadow_r;

    // Latch the upper half whenever the lower half is read.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            shadow_r <= 32'h0;
        end else if (rd_s && (adr_word_s == 4'h0)) begin
            shadow_r <= mtime_r[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign mtime_hi_rd_s = shadow_r;
`else
    assign mtime_hi_rd_s = mtime_r[63:32];
`endif

    // Read mux for the compare channel window; unimplemented channels read 0.
    always_comb begin
        cmp_rd_s = 32'h0;
        for (int k = 0; k < NUM_CMP; k++) begin
            cmp_rd_s = cmp_hit_s[k] ? (wb_adr[2] ? cmp_r[k][63:32] : cmp_r[k][31:0]) : cmp_rd_s;
        end
    end

    // Main register read mux.
    always_comb begin
        ctrl_rd_s                     = 32'h0;
        ctrl_rd_s[0]                  = en_r;
        ctrl_rd_s[8 +: PRESCALE_W]    = presc_r;
        case (adr_word_s)
            4'h0:    rdata_s = mtime_r[31:0];
            4'h1:    rdata_s = mtime_hi_rd_s;
            4'h2:    rdata_s = ctrl_rd_s;
            4'h3:    rdata_s = {{(32-NUM_CMP){1'b0}}, match_s};
            4'h4:    rdata_s = {{(32-NUM_CMP){1'b0}}, ien_r};
            default: rdata_s = wb_adr[5] ? cmp_rd_s : 32'h0;
        endcase
    end

    // Timer, control and interrupt-enable state.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            mtime_r <= 64'h0;
            pcnt_r  <= '0;
            en_r    <= 1'b0;
            presc_r <= '0;
            ien_r   <= '0;
        end else begin
            mtime_r <= mtime_nxt_s;
            pcnt_r  <= pcnt_nxt_s;
            if (wr_ctrl_s) begin
                en_r    <= (en_r & ~wmask_s[0]) | (wb_dat_w[0] & wmask_s[0]);
                presc_r <= (presc_r & ~wmask_s[8 +: PRESCALE_W])
                         | (wb_dat_w[8 +: PRESCALE_W] & wmask_s[8 +: PRESCALE_W]);
            end else begin
                en_r    <= en_r;
                presc_r <= presc_r;
            end
            if (wr_ien_s) begin
                ien_r <= (ien_r & ~wmask_s[NUM_CMP-1:0]) | (wb_dat_w[NUM_CMP-1:0] & wmask_s[NUM_CMP-1:0]);
            end else begin
                ien_r <= ien_r;
            end
        end
    end

    // Compare registers, written one 32-bit half at a time.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int k = 0; k < NUM_CMP; k++) begin
                cmp_r[k] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            for (int k = 0; k < NUM_CMP; k++) begin
                if (wr_s && cmp_hit_s[k] && !wb_adr[2]) begin
                    cmp_r[k][31:0] <= byte_merge(cmp_r[k][31:0], wb_dat_w, wb_sel);
                end else if (wr_s && cmp_hit_s[k] && wb_adr[2]) begin
                    cmp_r[k][63:32] <= byte_merge(cmp_r[k][63:32], wb_dat_w, wb_sel);
                end else begin
                    cmp_r[k] <= cmp_r[k];
                end
            end
        end
    end

    // Bus response and registered interrupt outputs.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_r       <= 1'b0;
            dat_r_r     <= 32'h0;
            irq_cmp_r   <= '0;
            irq_timer_r <= 1'b0;
        end else begin
            ack_r       <= req_s;
            dat_r_r     <= rd_s ? rdata_s : 32'h0;
            irq_cmp_r   <= match_s & ien_r;
            irq_timer_r <= |(match_s & ien_r);
        end
    end

endmodule

// File: tb/tb_rv_wb_timer.sv
// Directed self-checking bench for rv_wb_timer (NUM_CMP=2, PRESCALE_W=8).
// Read expectations are queued when a read is issued and popped when the
// acknowledge returns the data.

module tb_rv_wb_timer;

    logic        wb_clk   = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [5:0]  wb_adr   = 6'h0;
    logic [31:0] wb_dat_w = 32'h0;
    logic [3:0]  wb_sel   = 4'h0;
    logic        wb_we    = 1'b0;
    logic        wb_cyc   = 1'b0;
    logic        wb_stb   = 1'b0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic [1:0]  irq_cmp;
    logic        irq_timer;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    rv_wb_timer #(.NUM_CMP(2), .PRESCALE_W(8)) dut (
        .wb_clk    (wb_clk),
        .wb_rst_n  (wb_rst_n),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_sel    (wb_sel),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .irq_cmp   (irq_cmp),
        .irq_timer (irq_timer)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction, bounded to 8 cycles waiting for the ack.
    task automatic xfer(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
        @(negedge wb_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        acked = 1'b0;
        rdata = 32'h0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge wb_clk);
            #1;
            if (wb_ack) begin
                acked = 1'b1;
                rdata = wb_dat_r;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] d;
        logic        a;
        xfer(1'b1, adr, dat, sel, d, a);
        check("wr_ack", a, 1'b1);
    endtask

    task automatic rd(input logic [5:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        a;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        xfer(1'b0, adr, 32'h0, 4'h0, d, a);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ack"}, a, 1'b1);
        if (a) check(t, d, e);
    endtask

    task automatic rd_get(input logic [5:0] adr, output logic [31:0] d);
        logic a;
        xfer(1'b0, adr, 32'h0, 4'h0, d, a);
        check("rd_get_ack", a, 1'b1);
    endtask

    initial begin
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] hi_exp;

        // Reset state
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_ack", wb_ack, 1'b0);
        check("rst_dat", wb_dat_r, 32'h0);
        check("rst_irq_cmp", irq_cmp, 2'b00);
        check("rst_irq_timer", irq_timer, 1'b0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // Reset values through the bus
        rd(6'h00, 32'h0, "mtime_lo_rst");
        rd(6'h04, 32'h0, "mtime_hi_rst");
        rd(6'h08, 32'h0, "ctrl_rst");
        rd(6'h0C, 32'h0, "status_rst");
        rd(6'h10, 32'h0, "ien_rst");
        rd(6'h20, 32'hFFFF_FFFF, "cmp0_lo_rst");
        rd(6'h24, 32'hFFFF_FFFF, "cmp0_hi_rst");
        rd(6'h28, 32'hFFFF_FFFF, "cmp1_lo_rst");
        rd(6'h2C, 32'hFFFF_FFFF, "cmp1_hi_rst");
        rd(6'h18, 32'h0, "unmapped_18");
        @(posedge wb_clk);
        #1;
        check("ack_single", wb_ack, 1'b0);
        check("dat_idle", wb_dat_r, 32'h0);
        wr(6'h30, 32'hDEAD_BEEF);
        rd(6'h30, 32'h0, "cmp2_absent");
        wr(6'h10, 32'h0000_0003, 4'b0010);
        rd(6'h10, 32'h0, "ien_sel_masked");

        // Prescale: PRESC=3 gives one tick per 4 cycles
        wr(6'h08, 32'h0000_0301);
        rd(6'h08, 32'h0000_0301, "ctrl_rb");
        wr(6'h00, 32'h0);
        wr(6'h08, 32'h0000_0301);
        repeat (40) @(posedge wb_clk);
        wr(6'h08, 32'h0);
        rd(6'h00, 32'd10, "presc3_mtime");
        rd(6'h04, 32'h0, "presc3_mtime_hi");

        // PRESC=0: one tick per cycle, back-to-back reads are 2 cycles apart
        wr(6'h08, 32'h0000_0001);
        rd_get(6'h00, v0);
        rd_get(6'h00, v1);
        check("tick_rate", v1 - v0, 32'd2);
        wr(6'h08, 32'h0);

        // Interrupt assert and clear on channel 0
        wr(6'h00, 32'h0);
        wr(6'h04, 32'h0);
        wr(6'h20, 32'h20);
        wr(6'h24, 32'h0);
        wr(6'h10, 32'h1);
        wr(6'h08, 32'h1);
        repeat (32) @(posedge wb_clk);
        #1;
        check("irq_before", irq_cmp, 2'b00);
        check("irq_timer_before", irq_timer, 1'b0);
        @(posedge wb_clk);
        #1;
        check("irq_rise", irq_cmp, 2'b01);
        check("irq_timer_rise", irq_timer, 1'b1);
        rd(6'h0C, 32'h1, "status_ch0");
        wr(6'h20, 32'h1000);
        check("irq_hold_on_write", irq_timer, 1'b1);
        @(posedge wb_clk);
        #1;
        check("irq_clear", irq_cmp, 2'b00);
        check("irq_timer_clear", irq_timer, 1'b0);
        wr(6'h08, 32'h0);

        // Masking and second channel
        wr(6'h28, 32'h5);
        wr(6'h2C, 32'h0);
        rd(6'h0C, 32'h2, "status_ch1");
        check("irq_masked", irq_cmp, 2'b00);
        check("irq_timer_masked", irq_timer, 1'b0);
        wr(6'h10, 32'h3);
        check("irq_unmask_lag", irq_cmp, 2'b00);
        @(posedge wb_clk);
        #1;
        check("irq_unmask", irq_cmp, 2'b10);
        check("irq_timer_unmask", irq_timer, 1'b1);
        wr(6'h10, 32'h0);
        @(posedge wb_clk);
        #1;
        check("irq_timer_ien0", irq_timer, 1'b0);

        // Carry from LO into HI, with or without the shadow
        wr(6'h04, 32'h0);
        wr(6'h00, 32'hFFFF_FFFE);
        wr(6'h08, 32'h1);
        rd(6'h00, 32'hFFFF_FFFF, "carry_lo");
`ifdef TIMER_SHADOW_EN
        hi_exp = 32'h0;
`else
        hi_exp = 32'h1;
`endif
        rd(6'h04, hi_exp, "carry_hi");
        wr(6'h08, 32'h0);

        // Byte-masked MTIME_LO write colliding with a tick
        wr(6'h04, 32'h0);
        wr(6'h00, 32'h1234_5678);
        wr(6'h08, 32'h1);
        wr(6'h00, 32'h0000_0100, 4'b0001);
        wr(6'h08, 32'h0);
        rd(6'h00, 32'h1234_5602, "collide_lo");
        rd(6'h04, 32'h0, "collide_hi");

        // Reset during a pending request
        wr(6'h10, 32'h3);
        wr(6'h08, 32'h0000_0301);
        @(negedge wb_clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 6'h08;
        #2;
        wb_rst_n = 1'b0;
        @(posedge wb_clk);
        #1;
        check("rst_mid_ack", wb_ack, 1'b0);
        check("rst_mid_dat", wb_dat_r, 32'h0);
        check("rst_mid_irq", irq_timer, 1'b0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        rd(6'h08, 32'h0, "ctrl_after_rst");
        rd(6'h10, 32'h0, "ien_after_rst");
        rd(6'h00, 32'h0, "mtime_lo_after_rst");
        rd(6'h28, 32'hFFFF_FFFF, "cmp1_lo_after_rst");
        rd(6'h2C, 32'hFFFF_FFFF, "cmp1_hi_after_rst");
        check("irq_cmp_after_rst", irq_cmp, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
